// File: rtl/alu_issue_scheduler.sv
// Round-robin distributor of ALU issue packets into per-unit FIFOs.
// Packet MSB is the enable bit; commit_feedback_pack is {enable, flush}.
module alu_issue_scheduler #(
    parameter int unsigned ALU_UNIT_NUM = 2,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned PACK_W       = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PACK_W-1:0]                   issue_alu_pack_in,
    input  logic                                issue_alu_pack_valid,
    output logic                                issue_alu_pack_ready,
    output logic [ALU_UNIT_NUM-1:0][PACK_W-1:0] issue_alu_fifo_data_out,
    output logic [ALU_UNIT_NUM-1:0]             issue_alu_fifo_data_out_valid,
    input  logic [ALU_UNIT_NUM-1:0]             issue_alu_fifo_pop,
    input  logic [1:0]                          commit_feedback_pack,
    output logic                                alu_sched_busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned UNIT_W = (ALU_UNIT_NUM > 1) ? $clog2(ALU_UNIT_NUM) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PACK_W-1:0] mem_q    [ALU_UNIT_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [ALU_UNIT_NUM];
    logic [PTR_W-1:0]  rd_ptr_d [ALU_UNIT_NUM];
    logic [PTR_W-1:0]  wr_ptr_q [ALU_UNIT_NUM];
    logic [PTR_W-1:0]  wr_ptr_d [ALU_UNIT_NUM];
    logic [CNT_W-1:0]  count_q  [ALU_UNIT_NUM];
    logic [CNT_W-1:0]  count_d  [ALU_UNIT_NUM];
    logic [UNIT_W-1:0] rr_ptr_q, rr_ptr_d;

    logic                    flush;
    logic                    any_free;
    logic                    found;
    logic                    do_push;
    logic [UNIT_W-1:0]       target;
    logic [ALU_UNIT_NUM-1:0] full;
    logic [ALU_UNIT_NUM-1:0] push_sel;
    logic [ALU_UNIT_NUM-1:0] pop_ok;

    assign flush = commit_feedback_pack[1] & commit_feedback_pack[0];

    always_comb begin
        full     = '0;
        any_free = 1'b0;
        for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
            full[u]  = (count_q[u] == FULL_CNT);
            any_free = any_free | ~full[u];
        end
    end

    // Scan rr_ptr..N-1 first, then wrap around to 0..rr_ptr-1.
    always_comb begin
        target = '0;
        found  = 1'b0;
        for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
            if (!found && !full[u] && (UNIT_W'(u) >= rr_ptr_q)) begin
                target = UNIT_W'(u);
                found  = 1'b1;
            end
        end
        for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
            if (!found && !full[u]) begin
                target = UNIT_W'(u);
                found  = 1'b1;
            end
        end
    end

    assign issue_alu_pack_ready = ~rst & ~flush & any_free;
    assign do_push = issue_alu_pack_valid & issue_alu_pack_ready
                     & issue_alu_pack_in[PACK_W-1];

    always_comb begin
        for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
            push_sel[u] = do_push && (target == UNIT_W'(u));
            pop_ok[u]   = issue_alu_fifo_pop[u] && (count_q[u] != '0);
            wr_ptr_d[u] = push_sel[u] ? wr_ptr_q[u] + 1'b1 : wr_ptr_q[u];
            rd_ptr_d[u] = pop_ok[u] ? rd_ptr_q[u] + 1'b1 : rd_ptr_q[u];
            count_d[u]  = count_q[u] + CNT_W'(push_sel[u]) - CNT_W'(pop_ok[u]);
            if (flush) begin
                wr_ptr_d[u] = '0;
                rd_ptr_d[u] = '0;
                count_d[u]  = '0;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (do_push) begin
            rr_ptr_d = (target == UNIT_W'(ALU_UNIT_NUM - 1)) ? '0 : target + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
                rd_ptr_q[u] <= '0;
                wr_ptr_q[u] <= '0;
                count_q[u]  <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
                rd_ptr_q[u] <= rd_ptr_d[u];
                wr_ptr_q[u] <= wr_ptr_d[u];
                count_q[u]  <= count_d[u];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset: heads are masked to zero while count is zero.
    always_ff @(posedge clk) begin
        for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
            if (push_sel[u]) begin
                mem_q[u][wr_ptr_q[u]] <= issue_alu_pack_in;
            end
        end
    end

    always_comb begin
        for (int u = 0; u < int'(ALU_UNIT_NUM); u++) begin
            issue_alu_fifo_data_out_valid[u] = (count_q[u] != '0);
            issue_alu_fifo_data_out[u] = issue_alu_fifo_data_out_valid[u]
                                         ? mem_q[u][rd_ptr_q[u]] : '0;
        end
    end

    assign alu_sched_busy = |issue_alu_fifo_data_out_valid;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed scenarios plus random traffic vs a queue model.
module tb_alu_issue_scheduler;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int PW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [PW-1:0]        pack_in;
    logic                 pack_valid;
    logic                 pack_ready;
    logic [N-1:0][PW-1:0] data_out;
    logic [N-1:0]         data_valid;
    logic [N-1:0]         pop;
    logic [1:0]           cfb;
    logic                 busy;

    always #5 clk = ~clk;

    alu_issue_scheduler #(
        .ALU_UNIT_NUM(N),
        .FIFO_DEPTH  (D),
        .PACK_W      (PW)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .issue_alu_pack_in            (pack_in),
        .issue_alu_pack_valid         (pack_valid),
        .issue_alu_pack_ready         (pack_ready),
        .issue_alu_fifo_data_out      (data_out),
        .issue_alu_fifo_data_out_valid(data_valid),
        .issue_alu_fifo_pop           (pop),
        .commit_feedback_pack         (cfb),
        .alu_sched_busy               (busy)
    );

    logic [PW-1:0] q[N][$];
    int            rr;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(input bit en, input logic [7:0] rob);
        return {en, 23'($urandom), rob};
    endfunction

    task automatic model_clear();
        for (int u = 0; u < N; u++) q[u].delete();
        rr = 0;
    endtask

    task automatic check_outputs();
        bit any;
        any = 1'b0;
        for (int u = 0; u < N; u++) begin
            bit ev;
            ev  = (q[u].size() != 0);
            any = any | ev;
            check_val($sformatf("valid%0d", u), data_valid[u], ev);
            check_val($sformatf("data%0d", u), data_out[u], ev ? q[u][0] : '0);
        end
        check_val("busy", busy, any);
    endtask

    // One clock: check registered outputs, drive, check ready, advance the model at the edge.
    task automatic step(input bit v, input logic [PW-1:0] p, input logic [N-1:0] pp,
                        input logic [1:0] cf);
        bit fl, exp_rdy;
        int tgt;
        @(negedge clk);
        check_outputs();
        pack_valid = v;
        pack_in    = p;
        pop        = pp;
        cfb        = cf;
        #1;
        fl      = cf[1] && cf[0];
        exp_rdy = 1'b0;
        for (int u = 0; u < N; u++) if (q[u].size() < D) exp_rdy = 1'b1;
        if (fl) exp_rdy = 1'b0;
        check_val("ready", pack_ready, exp_rdy);
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            tgt = -1;
            if (v && exp_rdy && p[PW-1]) begin
                for (int i = 0; i < N; i++) begin
                    int idx;
                    idx = (rr + i) % N;
                    if (tgt < 0 && q[idx].size() < D) tgt = idx;
                end
            end
            for (int u = 0; u < N; u++) if (pp[u] && q[u].size() > 0) void'(q[u].pop_front());
            if (tgt >= 0) begin
                q[tgt].push_back(p);
                rr = (tgt + 1) % N;
            end
        end
        #1;
        pack_valid = 1'b0;
        pack_in    = '0;
        pop        = '0;
        cfb        = '0;
    endtask

    task automatic push(input logic [7:0] rob);
        step(1'b1, mk(1'b1, rob), '0, 2'b00);
    endtask

    task automatic do_flush();
        step(1'b0, '0, '0, 2'b11);
    endtask

    initial begin
        rst = 1'b1; pack_in = '0; pack_valid = 1'b0; pop = '0; cfb = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_val("rst_valid", data_valid, '0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_ready", pack_ready, 1'b0);
        rst = 1'b0;
        step(1'b0, '0, '0, 2'b00);

        // Round robin fill.
        push(1); push(2); push(3); push(4);
        check_val("rr_ready", pack_ready, 1'b0);
        check_val("rr_busy", busy, 1'b1);
        check_val("rr_head0", data_out[0][7:0], 8'd1);
        check_val("rr_head1", data_out[1][7:0], 8'd2);
        step(1'b1, mk(1'b1, 8'd99), '0, 2'b00);

        // Full unit skipped by the target search.
        do_flush();
        push(1); push(2); push(3);
        step(1'b0, '0, 2'b10, 2'b00);
        push(5);
        check_val("skip_head1", data_out[1][7:0], 8'd5);
        check_val("skip_head0", data_out[0][7:0], 8'd1);
        push(6);
        check_val("skip_full", pack_ready, 1'b0);
        check_val("skip_valid", data_valid, 2'b11);

        // Disabled packet completes handshake but is not stored.
        do_flush();
        push(1);
        step(1'b1, mk(1'b0, 8'd77), '0, 2'b00);
        check_val("bubble_valid", data_valid, 2'b01);
        push(2);
        check_val("bubble_head1", data_out[1][7:0], 8'd2);

        // Push and pop on the same unit.
        do_flush();
        push(1); push(7);
        step(1'b1, mk(1'b1, 8'd2), 2'b01, 2'b00);
        check_val("pp_head0", data_out[0][7:0], 8'd2);
        check_val("pp_ready", pack_ready, 1'b1);
        do_flush();
        step(1'b0, '0, 2'b11, 2'b00);
        check_val("pop_empty", data_valid, 2'b00);

        // Flush with a same-cycle push.
        push(1); push(2); push(3);
        step(1'b1, mk(1'b1, 8'd4), 2'b11, 2'b11);
        check_val("flush_valid", data_valid, 2'b00);
        check_val("flush_busy", busy, 1'b0);
        push(9);
        check_val("flush_rr", data_out[0][7:0], 8'd9);

        // Asynchronous reset mid-operation.
        push(10); push(11);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_valid", data_valid, 2'b00);
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_ready", pack_ready, 1'b0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 2000; k++) begin
            logic [1:0] cf;
            cf = ($urandom_range(0, 31) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step($urandom_range(0, 3) != 0, mk($urandom_range(0, 7) != 0, 8'(k)),
                 N'($urandom), cf);
        end
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
